// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Lets the pipeline's IF stage (instruction fetch) and MEM stage (load/store)
// share one single-port RAM. Each access is granted in IDLE. It then waits
// RD_LAT cycles in WAIT and is acknowledged with a one-cycle pulse in DONE.
// MEM normally wins a collision. After STARVE_MAX consecutive MEM grants while
// a fetch is waiting, IF is forced to win.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   if_req/if_addr        fetch request (level) and PC
//   if_ack/if_rdata       fetch done pulse; instruction held until next fetch ack
//   if_stall              if_req & ~if_ack, freezes PC / IF-ID
//   mem_re/mem_we         load / store request (level)
//   mem_addr/mem_wdata    load/store address and store data
//   mem_ack/mem_rdata     load/store done pulse; load data held until next load
//   ram_addr/ram_data     registered RAM address / write data
//   ram_wren              registered RAM write enable (one cycle per store)
//   ram_q                 RAM read data
//   busy                  arbiter is not in IDLE
//   proto_err             sticky: load and store requested together at a grant
//
// Optional feature macro: MEM_PORT_ARB_PERF_EN. It adds the perf_conflict
// and perf_if_wait saturating event counters.

module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
`ifdef MEM_PORT_ARB_PERF_EN
    output logic [15:0]       perf_conflict,
    output logic [15:0]       perf_if_wait,
`endif
    output logic              busy,
    output logic              proto_err
);

    localparam int              SC_W         = $clog2(STARVE_MAX + 1);
    localparam logic [1:0]      RD_LAT_C     = 2'(RD_LAT);
    localparam logic [SC_W-1:0] STARVE_MAX_C = SC_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [1:0]        cnt_r;
    logic [SC_W-1:0]   starve_cnt_r;
    logic              owner_mem_r;   // 1: MEM owns the current access
    logic              owner_rd_r;    // 1: current access is a read
    logic              any_mem_s;
    logic              grant_if_s;
    logic              grant_mem_s;
    logic              last_wait_s;
    logic              if_ack_r;
    logic              mem_ack_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] mem_rdata_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic [DATA_W-1:0] ram_data_r;
    logic              ram_wren_r;
    logic              proto_err_r;

    // Grant decode: MEM wins unless IF has waited through STARVE_MAX MEM grants
    always_comb begin
        any_mem_s   = mem_re | mem_we;
        grant_if_s  = 1'b0;
        grant_mem_s = 1'b0;
        if (state_r == ST_IDLE) begin
            grant_if_s  = if_req & (~any_mem_s | (starve_cnt_r == STARVE_MAX_C));
            grant_mem_s = any_mem_s & ~grant_if_s;
        end else begin
            grant_if_s  = 1'b0;
            grant_mem_s = 1'b0;
        end
        last_wait_s = (state_r == ST_WAIT) && (cnt_r == 2'd1);
    end

    // Next-state logic for the IDLE -> WAIT -> DONE access sequence
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_if_s || grant_mem_s) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (last_wait_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Access datapath: grant capture, write pulse, wait counter, read capture, acks
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= 2'd0;
            owner_mem_r <= 1'b0;
            owner_rd_r  <= 1'b0;
            if_ack_r    <= 1'b0;
            mem_ack_r   <= 1'b0;
            if_rdata_r  <= '0;
            mem_rdata_r <= '0;
            ram_addr_r  <= '0;
            ram_data_r  <= '0;
            ram_wren_r  <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            // Acks and the write enable are single-cycle pulses.
            if_ack_r   <= 1'b0;
            mem_ack_r  <= 1'b0;
            ram_wren_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_if_s) begin
                        owner_mem_r <= 1'b0;
                        owner_rd_r  <= 1'b1;
                        ram_addr_r  <= if_addr;
                        cnt_r       <= RD_LAT_C;
                    end else if (grant_mem_s) begin
                        owner_mem_r <= 1'b1;
                        ram_addr_r  <= mem_addr;
                        cnt_r       <= RD_LAT_C;
                        if (mem_we) begin
                            // A simultaneous load+store is performed as a store.
                            owner_rd_r <= 1'b0;
                            ram_data_r <= mem_wdata;
                            ram_wren_r <= 1'b1;
                            if (mem_re) begin
                                proto_err_r <= 1'b1;
                            end
                        end else begin
                            owner_rd_r <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 2'd1;
                    if (last_wait_s) begin
                        if (owner_mem_r) begin
                            mem_ack_r <= 1'b1;
                            if (owner_rd_r) begin
                                mem_rdata_r <= ram_q;
                            end
                        end else begin
                            if_ack_r   <= 1'b1;
                            if_rdata_r <= ram_q;
                        end
                    end
                end
                ST_DONE: begin
                    cnt_r <= 2'd0;
                end
                default: begin
                    cnt_r <= 2'd0;
                end
            endcase
        end
    end

    // Starvation counter: consecutive MEM grants taken while a fetch waits
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= '0;
        end else if (state_r == ST_IDLE) begin
            if (grant_if_s || !if_req) begin
                starve_cnt_r <= '0;
            end else if (grant_mem_s && (starve_cnt_r != STARVE_MAX_C)) begin
                starve_cnt_r <= starve_cnt_r + SC_W'(1);
            end
        end
    end

`ifdef MEM_PORT_ARB_PERF_EN
    logic [15:0] perf_conflict_r;
    logic [15:0] perf_if_wait_r;

    // Saturating event counters for arbitration conflicts and fetch stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_conflict_r <= 16'h0000;
            perf_if_wait_r  <= 16'h0000;
        end else begin
            if ((state_r == ST_IDLE) && if_req && any_mem_s && (perf_conflict_r != 16'hFFFF)) begin
                perf_conflict_r <= perf_conflict_r + 16'h0001;
            end
            if (if_stall && (perf_if_wait_r != 16'hFFFF)) begin
                perf_if_wait_r <= perf_if_wait_r + 16'h0001;
            end
        end
    end

    assign perf_conflict = perf_conflict_r;
    assign perf_if_wait  = perf_if_wait_r;
`endif

    assign if_ack    = if_ack_r;
    assign mem_ack   = mem_ack_r;
    assign if_rdata  = if_rdata_r;
    assign mem_rdata = mem_rdata_r;
    assign ram_addr  = ram_addr_r;
    assign ram_data  = ram_data_r;
    assign ram_wren  = ram_wren_r;
    assign proto_err = proto_err_r;
    assign if_stall  = if_req & ~if_ack_r;
    assign busy      = (state_r != ST_IDLE);

endmodule
